limb_add_stream: RTL

//  Multi-word streaming adder/subtractor. Operands arrive as DATA_WIDTH-bit limbs,
//  LS limb first, on a valid/ready stream. Each limb pair is summed by one

---
 rtl/limb_add_stream_if.sv | 34 +++
 rtl/limb_add_stream.sv | 80 ++++++++
 2 files changed

// File: rtl/limb_add_stream_if.sv
// ============================================================================
// limb_add_stream_if : input/output limb streams of the streaming adder
// Rev 1.0
// ============================================================================
`default_nettype none

interface limb_add_stream_if #(
  parameter int DATA_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic                  in_ci;
  logic                  in_sub;
  logic                  in_last;
  logic                  in_vld;
  logic                  in_rd;
  logic [DATA_WIDTH-1:0] out_s;
  logic                  out_co;
  logic                  out_last;
  logic                  out_vld;
  logic                  out_rd;

  modport master (
    output in_a, in_b, in_ci, in_sub, in_last, in_vld, out_rd,
    input  in_rd, out_s, out_co, out_last, out_vld
  );

  modport slave (
    input  in_a, in_b, in_ci, in_sub, in_last, in_vld, out_rd,
    output in_rd, out_s, out_co, out_last, out_vld
  );
endinterface

`default_nettype wire

// File: rtl/limb_add_stream.sv
// ============================================================================
// limb_add_stream : multi-limb streaming add/sub, LS limb first, 1-clk latency
// Rev 1.0
// ============================================================================
`default_nettype none

module limb_add_stream #(
  parameter int DATA_WIDTH = 4
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  limb_add_stream_if.slave bus
);

  typedef enum logic [0:0] {
    ST_FIRST = 1'b0,
    ST_MID   = 1'b1
  } state_t;

  state_t                state;
  logic                  carry;
  logic                  sub_q;
  logic [DATA_WIDTH-1:0] s_q;
  logic                  co_q;
  logic                  last_q;
  logic                  vld_q;

  logic                  accept;
  logic                  sub_eff;
  logic                  cin;
  logic [DATA_WIDTH-1:0] b_x;
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH:0]   c;

  assign bus.in_rd    = !vld_q | bus.out_rd;
  assign bus.out_s    = s_q;
  assign bus.out_co   = co_q;
  assign bus.out_last = last_q;
  assign bus.out_vld  = vld_q;

  assign accept  = bus.in_vld & bus.in_rd;
  // Operation and external carry are taken from the first limb only.
  assign sub_eff = (state == ST_FIRST) ? bus.in_sub : sub_q;
  assign cin     = (state == ST_FIRST) ? (bus.in_ci ^ bus.in_sub) : carry;
  assign b_x     = bus.in_b ^ {DATA_WIDTH{sub_eff}};
  assign c[0]    = cin;

  generate
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_fa
      assign sum[i]   = bus.in_a[i] ^ b_x[i] ^ c[i];
      assign c[i+1]   = (bus.in_a[i] & b_x[i]) | (c[i] & (bus.in_a[i] ^ b_x[i]));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_FIRST;
      carry  <= 1'b0;
      sub_q  <= 1'b0;
      s_q    <= '0;
      co_q   <= 1'b0;
      last_q <= 1'b0;
      vld_q  <= 1'b0;
    end else if (accept) begin
      s_q    <= sum;
      co_q   <= bus.in_last ? c[DATA_WIDTH] : 1'b0;
      last_q <= bus.in_last;
      vld_q  <= 1'b1;
      sub_q  <= sub_eff;
      // Clearing carry at packet end keeps packets independent.
      carry  <= bus.in_last ? 1'b0 : c[DATA_WIDTH];
      state  <= bus.in_last ? ST_FIRST : ST_MID;
    end else if (bus.out_rd) begin
      vld_q  <= 1'b0;
    end
  end

endmodule

`default_nettype wire
